// File: rtl/gpio_hex_display_if.sv
// gpio_hex_display_if: value/mode from the CPU side and segment/status back to it
interface gpio_hex_display_if;
  logic [31:0] value;
  logic        dec_mode;
  logic [55:0] hex_out;
  logic        busy;
  logic        overflow;
  modport master (output value, dec_mode, input hex_out, busy, overflow);
  modport slave  (input value, dec_mode, output hex_out, busy, overflow);
endinterface

// File: rtl/gpio_hex_display.sv
// gpio_hex_display: drives eight 7-segment digits from a 32-bit word in hex or double-dabble decimal
module gpio_hex_display #(
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  gpio_hex_display_if.slave   bus_io
);
  typedef enum logic [1:0] {IDLE, HEXLOAD, SHIFT, DECLOAD} state_t;
  localparam logic [15:0][6:0] SEG = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [55:0] RST_HEX = BLANK_LZ ? {{7{7'h7F}}, 7'h40} : {8{7'h40}};
  state_t      state_q, state_d;
  logic [31:0] val_q, val_d, bin_q, bin_d;
  logic        mode_q, mode_d, ovf_q, ovf_d;
  logic [39:0] bcd_q, bcd_d, adj;
  logic [4:0]  cnt_q, cnt_d;
  logic [55:0] hex_q, hex_d;
  // A digit is blank when it and every more significant digit is zero; digit 0 always shows
  function automatic logic [55:0] render(input logic [31:0] v);
    logic [55:0] r;
    logic        lz;
    lz = 1'b1;
    r  = '0;
    for (int i = 7; i >= 0; i--) begin
      lz = lz && (v[4*i+:4] == 4'd0) && (i != 0);
      r[7*i+:7] = (BLANK_LZ && lz) ? 7'h7F : SEG[v[4*i+:4]];
    end
    return r;
  endfunction
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 10; i++)
      adj[4*i+:4] = (bcd_q[4*i+:4] >= 4'd5) ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    mode_d  = mode_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (bus_io.value != val_q || bus_io.dec_mode != mode_q) begin
        val_d   = bus_io.value;
        mode_d  = bus_io.dec_mode;
        bcd_d   = '0;
        bin_d   = bus_io.value;
        cnt_d   = '0;
        state_d = bus_io.dec_mode ? SHIFT : HEXLOAD;
      end
      HEXLOAD: begin
        hex_d   = render(val_q);
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj[38:0], bin_q, 1'b0};
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? DECLOAD : SHIFT;
      end
      DECLOAD: begin
        ovf_d   = |bcd_q[39:32];
        hex_d   = (|bcd_q[39:32]) ? {8{7'h3F}} : render(bcd_q[31:0]);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      mode_q  <= 1'b0;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= RST_HEX;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus_io.hex_out  = hex_q;
  assign bus_io.overflow = ovf_q;
  assign bus_io.busy     = (state_q == SHIFT) || (state_q == DECLOAD);
endmodule

// File: tb/tb_gpio_hex_display.sv
// tb_gpio_hex_display: vector table, randomized model comparison and corner sequences for both blanking options
module tb_gpio_hex_display;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] v = '0;
  logic        m = 1'b0;
  int          n_pass = 0;
  int          n_tot = 0;
  logic [55:0] prev0, prev1;
  logic [31:0] cur_v;
  logic        cur_m;
  localparam logic [6:0] CODES [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct {
    logic [31:0] v;
    logic        m;
    logic [55:0] hex;
    logic        ovf;
  } vec_t;
  vec_t tbl [10];

  gpio_hex_display_if if0 ();
  gpio_hex_display_if if1 ();
  assign if0.value = v;
  assign if0.dec_mode = m;
  assign if1.value = v;
  assign if1.dec_mode = m;

  gpio_hex_display #(.BLANK_LZ(1'b0)) dut0 (.clk(clk), .rst(rst), .bus_io(if0));
  gpio_hex_display #(.BLANK_LZ(1'b1)) dut1 (.clk(clk), .rst(rst), .bus_io(if1));

  always #5 clk = ~clk;

  function automatic logic [55:0] model(input logic [31:0] val, input logic dec, input bit blz);
    logic [55:0] r;
    longint      base, p, d;
    base = dec ? 10 : 16;
    p = 1;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      d = (longint'(val) / p) % base;
      if (dec && val > 32'd99999999) r[7*i+:7] = 7'h3F;
      else if (blz && i > 0 && longint'(val) < p) r[7*i+:7] = 7'h7F;
      else r[7*i+:7] = CODES[int'(d)];
      p = p * base;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Applies a new value just after a negedge and follows it through to the display update
  task automatic run_vec(input logic [31:0] nv, input logic nm, input logic [55:0] e0, input logic eo);
    logic [55:0] e1;
    int          nb, lat;
    e1 = model(nv, nm, 1'b1);
    lat = nm ? 33 : 1;
    v = nv;
    m = nm;
    @(posedge clk);
    nb = 0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      nb += int'(if0.busy);
      if (k == lat) chk("hold_before_update", 64'(if0.hex_out), 64'(prev0));
      @(posedge clk);
    end
    @(negedge clk);
    chk("busy_cycles", 64'(nb), nm ? 64'd33 : 64'd0);
    chk("hex_blz0", 64'(if0.hex_out), 64'(e0));
    chk("hex_blz1", 64'(if1.hex_out), 64'(e1));
    chk("ovf_blz0", 64'(if0.overflow), 64'(eo));
    chk("ovf_blz1", 64'(if1.overflow), 64'(eo));
    chk("busy_done", 64'(if0.busy), 64'd0);
    prev0 = e0;
    prev1 = e1;
    cur_v = nv;
    cur_m = nm;
  endtask

  initial begin
    logic [31:0] rv;
    logic        rm;
    tbl[0] = '{32'hDEADBEEF, 1'b0, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}, 1'b0};
    tbl[1] = '{32'd12345678, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 1'b0};
    tbl[2] = '{32'd100000000, 1'b1, {8{7'h3F}}, 1'b1};
    tbl[3] = '{32'd99999999, 1'b1, {8{7'h10}}, 1'b0};
    tbl[4] = '{32'hFFFFFFFF, 1'b1, {8{7'h3F}}, 1'b1};
    tbl[5] = '{32'hFFFFFFFF, 1'b0, {8{7'h0E}}, 1'b0};
    tbl[6] = '{32'h00000000, 1'b0, {8{7'h40}}, 1'b0};
    tbl[7] = '{32'd42, 1'b1, {{6{7'h40}}, 7'h19, 7'h24}, 1'b0};
    tbl[8] = '{32'd0, 1'b1, {8{7'h40}}, 1'b0};
    tbl[9] = '{32'h00000A05, 1'b0, {{5{7'h40}}, 7'h08, 7'h40, 7'h12}, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hex_blz0", 64'(if0.hex_out), 64'({8{7'h40}}));
    chk("rst_hex_blz1", 64'(if1.hex_out), 64'({{7{7'h7F}}, 7'h40}));
    chk("rst_busy", 64'(if0.busy), 64'd0);
    chk("rst_ovf", 64'(if0.overflow), 64'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_hex_blz0", 64'(if0.hex_out), 64'({8{7'h40}}));
    chk("idle_hex_blz1", 64'(if1.hex_out), 64'({{7{7'h7F}}, 7'h40}));
    chk("idle_busy", 64'(if0.busy), 64'd0);
    prev0 = {8{7'h40}};
    prev1 = {{7{7'h7F}}, 7'h40};

    for (int i = 0; i < 10; i++) run_vec(tbl[i].v, tbl[i].m, tbl[i].hex, tbl[i].ovf);

    for (int i = 0; i < 40; i++) begin
      rv = $urandom >> $urandom_range(0, 31);
      rm = 1'($urandom);
      if (rv == cur_v && rm == cur_m) rm = ~rm;
      run_vec(rv, rm, model(rv, rm, 1'b0), rm && rv > 32'd99999999);
    end

    // Input change mid-conversion is picked up after the first result lands
    v = 32'd12345678;
    m = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    v = 32'd42;
    repeat (24) @(posedge clk);
    @(negedge clk);
    chk("midchg_first", 64'(if0.hex_out), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));
    chk("midchg_idle", 64'(if0.busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midchg_restart_busy", 64'(if0.busy), 64'd1);
    repeat (33) @(posedge clk);
    @(negedge clk);
    chk("midchg_second_blz0", 64'(if0.hex_out), 64'({{6{7'h40}}, 7'h19, 7'h24}));
    chk("midchg_second_blz1", 64'(if1.hex_out), 64'({{6{7'h7F}}, 7'h19, 7'h24}));
    chk("midchg_second_busy", 64'(if0.busy), 64'd0);

    // Reset in the middle of a conversion, then the held value restarts it
    v = 32'd7654321;
    @(posedge clk);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_hex_blz0", 64'(if0.hex_out), 64'({8{7'h40}}));
    chk("midrst_hex_blz1", 64'(if1.hex_out), 64'({{7{7'h7F}}, 7'h40}));
    chk("midrst_busy", 64'(if0.busy), 64'd0);
    chk("midrst_ovf", 64'(if0.overflow), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_busy", 64'(if0.busy), 64'd1);
    repeat (33) @(posedge clk);
    @(negedge clk);
    chk("postrst_hex_blz0", 64'(if0.hex_out), 64'({7'h40, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}));
    chk("postrst_hex_blz1", 64'(if1.hex_out), 64'(model(32'd7654321, 1'b1, 1'b1)));
    chk("postrst_busy_done", 64'(if0.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
